// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit.
// One radix-2 step per cycle; fixed latency of XLEN CALC cycles plus one DONE cycle.
// Operands are reduced to magnitudes on accept; sign correction is applied
// on the final iteration, when the result register is written.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int unsigned   CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sa;
  logic                w_sb;
  logic                w_b_zero;
  logic                w_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;

  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic                w_div_ge;
  logic [XLEN-1:0]     w_div_rem;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_result;

  // Operand sign decode, magnitudes and the single result-negate flag per op.
  // Divide by zero keeps the all-ones quotient unnegated; remainder follows dividend sign.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'd2:                   w_a_signed = 1'b1;
      default:                ;
    endcase
    w_sa     = w_a_signed & a[XLEN-1];
    w_sb     = w_b_signed & b[XLEN-1];
    w_a_mag  = w_sa ? -a : a;
    w_b_mag  = w_sb ? -b : b;
    w_b_zero = (b == '0);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: w_neg = w_sa ^ w_sb;
      3'd4:                   w_neg = (w_sa ^ w_sb) & ~w_b_zero;
      3'd6:                   w_neg = w_sa;
      default:                w_neg = 1'b0;
    endcase
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step, plus final result select.
  // Divide layout: r_acc upper half = partial remainder, lower half = dividend/quotient.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_rem   = w_div_ge ? (w_div_shift[XLEN-1:0] - r_opnd) : w_div_shift[XLEN-1:0];
    w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};
    w_acc_next  = r_op[2] ? w_div_next : w_mul_next;
    w_prod      = r_neg ? -w_mul_next : w_mul_next;
    w_quo       = w_div_next[XLEN-1:0];
    w_rem       = w_div_next[2*XLEN-1:XLEN];
    case (r_op)
      3'd0:             w_result = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: w_result = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_result = r_neg ? -w_quo : w_quo;
      default:          w_result = r_neg ? -w_rem : w_rem;
    endcase
  end

  // Control FSM and datapath registers; flush abandons work but never touches the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
            r_opnd  <= op[2] ? w_b_mag : w_a_mag;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_result;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
